// File: rtl/ar_channel.sv
// Read-address stage of the AXI width adapter: splits one wide AR request into
// narrow INCR sub-bursts (<=256 beats each) and logs one entry per request for the read-data collector.
module ar_channel #(
  parameter int M_DATA_WIDTH = 128,
  parameter int S_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int ARID_WIDTH   = 3,
  parameter int SUB_TXN_CNT  = 3,
  parameter int SUB_XFER_CNT = 3,
  parameter int FF_DATA_IN   = SUB_TXN_CNT + SUB_XFER_CNT
) (
  input  logic                  aclk,
  input  logic                  arst_n,
  input  logic [ARID_WIDTH-1:0] m_arid,
  input  logic [ADDR_WIDTH-1:0] m_araddr,
  input  logic [7:0]            m_arlen,
  input  logic [2:0]            m_arsize,
  input  logic [1:0]            m_arburst,
  input  logic                  m_arvalid,
  output logic                  m_arready,
  output logic [ARID_WIDTH-1:0] s_arid,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic [7:0]            s_arlen,
  output logic [2:0]            s_arsize,
  output logic [1:0]            s_arburst,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  output logic [FF_DATA_IN-1:0] xfer_data_i,
  output logic                  xfer_wr_valid_i,
  input  logic                  xfer_full_o
);
  localparam int M_BYTES   = M_DATA_WIDTH / 8;
  localparam int S_BYTES   = S_DATA_WIDTH / 8;
  localparam int RATIO_MAX = M_BYTES / S_BYTES;
  localparam int BEAT_W    = 9 + $clog2(RATIO_MAX);
  localparam int STEP      = 256 * S_BYTES;
  localparam logic [2:0] S_SIZE = 3'($clog2(S_BYTES));

  typedef enum logic {IDLE, ISSUE} state_t;

  typedef struct packed {
    logic [ARID_WIDTH-1:0] id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ar_req_t;

  state_t            state, state_nxt;
  ar_req_t           req_q;
  logic [BEAT_W-1:0] remaining;
  logic              accept, sub_done, last_sub;

  // Only INCR is generated on the narrow side; the wide burst type is dropped.
  logic unused_burst;
  assign unused_burst = ^m_arburst;

  // Request decode: narrow beats per wide beat, total narrow beats, sub-burst count.
  logic [2:0]              up_shift;
  logic [BEAT_W-1:0]       beats, beats_rnd, rem_next;
  logic [SUB_XFER_CNT-1:0] ratio;
  logic [SUB_TXN_CNT-1:0]  total_sub;
  logic [ADDR_WIDTH-1:0]   base;
  logic [7:0]              first_len, next_len;
  logic [2:0]              n_size;

  always_comb begin
    up_shift  = (m_arsize > S_SIZE) ? (m_arsize - S_SIZE) : 3'd0;
    beats     = (BEAT_W'(m_arlen) + BEAT_W'(1)) << up_shift;
    beats_rnd = beats + BEAT_W'(255);
    ratio     = SUB_XFER_CNT'(1) << up_shift;
    total_sub = SUB_TXN_CNT'(beats_rnd >> 8);
    base      = m_araddr & ~((ADDR_WIDTH'(1) << m_arsize) - ADDR_WIDTH'(1));
    first_len = (beats > BEAT_W'(256)) ? 8'd255 : 8'(beats - BEAT_W'(1));
    n_size    = (m_arsize >= S_SIZE) ? S_SIZE : m_arsize;
    rem_next  = remaining - BEAT_W'(256);
    next_len  = (rem_next > BEAT_W'(256)) ? 8'd255 : 8'(rem_next - BEAT_W'(1));
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    m_arready = 1'b0;
    accept    = 1'b0;
    sub_done  = 1'b0;
    last_sub  = (remaining <= BEAT_W'(256));
    case (state)
      IDLE: begin
        // arst_n term keeps ready low while reset is held, not just after the edge.
        m_arready = !xfer_full_o && arst_n;
        accept    = m_arready && m_arvalid;
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        sub_done = s_arready;
        if (s_arready && last_sub) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      req_q           <= '0;
      remaining       <= '0;
      xfer_data_i     <= '0;
      xfer_wr_valid_i <= 1'b0;
    end else begin
      xfer_wr_valid_i <= accept;
      if (accept) begin
        req_q       <= '{id: m_arid, addr: base, len: first_len, size: n_size, burst: 2'b01};
        remaining   <= beats;
        xfer_data_i <= {ratio, total_sub};
      end else if (sub_done && !last_sub) begin
        remaining  <= rem_next;
        req_q.addr <= req_q.addr + ADDR_WIDTH'(STEP);
        req_q.len  <= next_len;
      end
    end
  end

  assign s_arvalid = (state == ISSUE);
  assign s_arid    = req_q.id;
  assign s_araddr  = req_q.addr;
  assign s_arlen   = req_q.len;
  assign s_arsize  = req_q.size;
  assign s_arburst = req_q.burst;
endmodule

// File: doc/ar_channel.md
# ar_channel

Read-address stage of the AXI data-width adapter; sits directly upstream of the read-data collector. It accepts wide-side AR requests (M_DATA_WIDTH beats), splits each into one or more AXI4 INCR bursts on the narrow side (S_DATA_WIDTH beats, ≤256 beats each), and pushes one bookkeeping entry per request into the transfer FIFO. The read-data stage pops that entry to regroup narrow beats into wide beats and to count narrow `rlast`s.

## Interface
- `M_DATA_WIDTH`, 128: wide-side data width; M_BYTES = M_DATA_WIDTH/8.
- `S_DATA_WIDTH`, 32: narrow-side data width; S_BYTES = S_DATA_WIDTH/8.
- `ADDR_WIDTH`, 32: address width.
- `ARID_WIDTH`, 3: ID width.
- `SUB_TXN_CNT`, 3: width of total_sub_txn field.
- `SUB_XFER_CNT`, 3: width of sub_xfer_cnt field.
- `FF_DATA_IN`, SUB_TXN_CNT+SUB_XFER_CNT: FIFO entry width.

- `aclk` in 1: clock.
- `arst_n` in 1: reset, asynchronous, active-low.
- `m_arid` in ARID_WIDTH; `m_araddr` in ADDR_WIDTH; `m_arlen` in 8; `m_arsize` in 3; `m_arburst` in 2: wide-side request.
- `m_arvalid` in 1 / `m_arready` out 1: wide-side AR handshake.
- `s_arid` out ARID_WIDTH; `s_araddr` out ADDR_WIDTH; `s_arlen` out 8; `s_arsize` out 3; `s_arburst` out 2: narrow-side request (registered).
- `s_arvalid` out 1 / `s_arready` in 1: narrow-side AR handshake.
- `xfer_data_i` out FF_DATA_IN: FIFO entry; [5:3] sub_xfer_cnt, [2:0] total_sub_txn.
- `xfer_wr_valid_i` out 1: FIFO write strobe, one cycle per accepted request.
- `xfer_full_o` in 1: FIFO full.

## Operation
- FSM states IDLE, ISSUE.
- IDLE: `m_arready` = (state==IDLE) && !xfer_full_o (combinational from state reg and full). Handshake → capture request, go ISSUE.
- Per request: ratio = max(1, 2^m_arsize / S_BYTES) ∈ {1,2,4}; beats = (m_arlen+1)·ratio (11 bits, ≤1024); total_sub_txn = ceil(beats/256) ∈ 1..4.
- FIFO entry: sub_xfer_cnt = ratio, total_sub_txn as above; written exactly once, cycle after handshake.
- Base address = m_araddr with low m_arsize bits cleared (unaligned start normalized).
- Sub-transaction k: s_araddr = base + k·256·S_BYTES; s_arlen = min(256, remaining)−1; remaining starts at beats, decremented by 256 per accepted sub.
- s_arsize = log2(S_BYTES) if m_arsize ≥ log2(S_BYTES), else m_arsize; s_arburst = 2'b01 (INCR) always; s_arid = captured m_arid.
- m_arburst FIXED/WRAP unsupported: forwarded as INCR, no error signalling.
- m_arsize > log2(M_BYTES) is illegal input; behaviour undefined.
- Sub-bursts never cross 4 KB because the wide request itself does not.
- ISSUE: s_arvalid=1; on s_arready, if last sub → IDLE (s_arvalid low next cycle), else load next sub (address +0x400 for 32-bit narrow side, remaining −256), s_arvalid stays high.

## Timing
- Reset values: m_arready 0 (state IDLE but output forced low while arst_n low), s_arvalid 0, s_araddr/s_arlen/s_arsize/s_arburst/s_arid 0, xfer_data_i 0, xfer_wr_valid_i 0; internal counters 0.
- m handshake at cycle T → s_arvalid and first sub fields valid at T+1; xfer_wr_valid_i pulses at T+1 only.
- Back-to-back subs: one per cycle when s_arready held high.
- s_ar* fields stable while s_arvalid && !s_arready (AXI rule).
- Last sub accepted at cycle U → m_arready may assert at U+1 (one idle cycle min between requests).
- xfer_full_o high in IDLE blocks acceptance; in ISSUE it is ignored (entry already written).
- Reset mid-ISSUE: all outputs to reset values immediately, pending subs discarded, no FIFO write.

## Test plan
- m_araddr 0x1008, arlen 3, arsize 4, id 5 → one sub: s_araddr 0x1000, s_arlen 15, s_arsize 2, s_arburst 1, s_arid 5; xfer_data_i 6'b100_001, single strobe.
- arlen 255, arsize 4, addr 0x0 → four subs at 0x000/0x400/0x800/0xC00, each s_arlen 255, back-to-back with s_arready=1; entry 6'b100_100.
- arlen 199, arsize 3, addr 0x2000 → subs (0x2000, len 255), (0x2400, len 143); entry 6'b010_010.
- Narrow request: arlen 7, arsize 1, addr 0x3002 → one sub 0x3002, len 7, size 1; entry 6'b001_001.
- s_arready low 5 cycles in ISSUE → s_ar* unchanged; xfer_full_o=1 in IDLE with m_arvalid=1 → m_arready 0, no strobe until full drops.
- arst_n low during second of four subs → s_arvalid 0 same cycle; after release, m_arready 1, new request issues cleanly.
